image_loader: RTL

Host-side initiator for the inference pipeline. It accepts one image as a valid/ready pixel stream and writes the pixels into the image RAM that the network reads. It then pulses the network start, waits for the network's done, captures the prediction and returns it on a result handshake. It sits between the host/DMA stream and the network top (start/done/prediction interface).

---
 rtl/image_loader.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//   Host-side initiator for the inference pipeline. It takes one image as a
//   valid/ready pixel stream and writes it into the image RAM. Then it pulses
//   the network start and waits for a rising edge on net_done. It captures the
//   prediction a fixed number of cycles after that edge and returns it on a
//   result handshake. If no edge arrives in time, it returns a timeout result.
//
// Ports
//   clk, rst_n         single rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready    pixel stream handshake; s_data is the pixel value and
//   s_data/s_last      s_last marks the final beat of a frame
//   wr_en/wr_addr/     image RAM write port; registered, one cycle after the
//   wr_data            beat is accepted
//   net_start          one-cycle start pulse to the network
//   net_done           network done level; only its rising edge matters
//   net_prediction     network argmax output, sampled CAPTURE_DELAY cycles
//                      after the net_done edge
//   res_valid/         result handshake; res_data and res_timeout are held
//   res_ready          stable until the result is consumed
//   res_data           captured prediction, 0 on timeout
//   res_timeout        res_data is a timeout result
//   err_len            sticky frame-length error, cleared only by reset
//   frame_cnt          number of results delivered, wraps at 256
// -----------------------------------------------------------------------------
module image_loader #(
  parameter int NUM_PIXELS    = 784,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 10,
  parameter int CAPTURE_DELAY = 2,
  parameter int WAIT_TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              net_start,
  input  logic              net_done,
  input  logic [DATA_W-1:0] net_prediction,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  input  logic              res_ready,
  output logic              err_len,
  output logic [7:0]        frame_cnt
);

  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int CAP_W  = (CAPTURE_DELAY < 1) ? 1 : $clog2(CAPTURE_DELAY + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CAP_W-1:0]  CAP_LAST  = CAP_W'(CAPTURE_DELAY);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CAP_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic              cap_busy_q, cap_busy_d;
  logic              prev_done_q;

  logic              s_ready_q, s_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              net_start_q, net_start_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_timeout_q, res_timeout_d;
  logic              err_len_q, err_len_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic beat;
  logic done_rise;

  assign beat      = s_valid & s_ready_q;
  // prev_done_q follows net_done in every state, START included. If done is
  // already high when WAIT is entered, prev_done_q is high too, so it cannot
  // look like an edge. A fresh 0->1 transition is needed.
  assign done_rise = net_done & ~prev_done_q;

  always_comb begin
    // NOTE: every *_d gets a default before the case, so no path can leave a
    // signal unassigned and infer a latch.
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    cap_cnt_d     = cap_cnt_q;
    cap_busy_d    = cap_busy_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    net_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    err_len_d     = err_len_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_cnt_q;
          wr_data_d = s_data;
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            if (s_last) begin
              state_d = ST_START;
            end else begin
              // The frame is too long. Keep the first NUM_PIXELS pixels and
              // drop everything up to s_last.
              err_len_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (s_last) begin
            // The frame is too short. The pixels already written are left in
            // place and the loader waits for a fresh frame.
            err_len_d = 1'b1;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (beat && s_last) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        net_start_d = 1'b1;
        wait_cnt_d  = '0;
        cap_cnt_d   = '0;
        cap_busy_d  = 1'b0;
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        if (cap_busy_q) begin
          // An edge has been seen. Count out the capture delay; the timeout
          // no longer applies.
          if (cap_cnt_q == CAP_LAST) begin
            res_data_d    = net_prediction;
            res_timeout_d = 1'b0;
            res_valid_d   = 1'b1;
            cap_busy_d    = 1'b0;
            state_d       = ST_RESULT;
          end else begin
            cap_cnt_d = cap_cnt_q + 1'b1;
          end
        end else if (done_rise) begin
          if (CAPTURE_DELAY == 0) begin
            res_data_d    = net_prediction;
            res_timeout_d = 1'b0;
            res_valid_d   = 1'b1;
            state_d       = ST_RESULT;
          end else begin
            cap_busy_d = 1'b1;
            cap_cnt_d  = CAP_W'(1);
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          pix_cnt_d   = '0;
          state_d     = ST_LOAD;
        end
      end

      default: state_d = ST_LOAD;
    endcase

    // s_ready is registered. It is high whenever the next state takes beats.
    s_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      pix_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      cap_cnt_q     <= '0;
      cap_busy_q    <= 1'b0;
      prev_done_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      net_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      cap_cnt_q     <= cap_cnt_d;
      cap_busy_q    <= cap_busy_d;
      prev_done_q   <= net_done;
      s_ready_q     <= s_ready_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      net_start_q   <= net_start_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      err_len_q     <= err_len_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign net_start   = net_start_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign err_len     = err_len_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
